mem_stage_ctrl: RTL and testbench
=================================

// Module: mem_stage_ctrl
// PURPOSE
// Consumer side of the EX/MEM pipeline register: takes the EX/MEM outputs, performs the
// data-memory access over a req/ack handshake, and drives the MEM/WB fields.
// Stalls the EX/MEM register (drives its write enable low) while an access is outstanding.
// Non-memory instructions pass through to MEM/WB in one cycle.
// PARAMETERS
// W        16   datapath / address width
// TIMEOUT  15   max cycles MemReq may wait for MemAck before abort (1..255)
// PORTS
// CLK        in   1  clock, all state on rising edge
// Reset      in   1  asynchronous, active-low reset
// IRegWrite  in   1  from EX/MEM: writeback enable
// IMemWrite  in   1  from EX/MEM: store
// IMemRead   in   1  from EX/MEM: load
// IRegStore  in   1  from EX/MEM: writeback-source select, passed through
// IPCP2      in   W  from EX/MEM: PC+2, passed through
// IALUResult in   W  from EX/MEM: memory address / ALU result
// I3rdArg    in   W  from EX/MEM: store data
// IRd        in   W  from EX/MEM: destination register
// MemAck     in   1  memory completion; valid only while MemReq=1
// MemRData   in   W  load data, valid with MemAck
// MemReq     out  1  registered request, held until ack or timeout
// MemWE      out  1  registered: 1=write, 0=read; stable while MemReq=1
// MemAddr    out  W  registered address; stable while MemReq=1
// MemWData   out  W  registered store data; stable while MemReq=1
// EXMEMWrite out  1  combinational EX/MEM write enable; 0 = stall
// MemErr     out  1  registered one-cycle pulse on timeout abort
// ORegWrite, ORegStore  out 1 ; OPCP2, OALUResult, OMemData, ORd  out W : MEM/WB fields
// BEHAVIOUR
// - Reset=0 (async, immediate): state IDLE, timeout counter 0, every registered output 0.
//   Covers MemReq, MemWE, MemAddr, MemWData, MemErr and all O* fields. Aborts any access.
// - access = IMemRead | IMemWrite; both set -> write (MemWE=1), read ignored.
// - FSM IDLE:
//   - access=0: EXMEMWrite=1.
//     - Next edge: MEM/WB <= inputs. OMemData <= 0.
//   - access=1: EXMEMWrite=0.
//     - Next edge: MemReq<=1; MemWE/MemAddr/MemWData <= IMemWrite/IALUResult/I3rdArg.
//     - Same edge: ORegWrite<=0 and ORegStore<=0 (bubble). Counter<=0. -> WAIT.
// - FSM WAIT:
//   - MemAck=1: EXMEMWrite=1.
//     - Next edge: MemReq<=0; MEM/WB <= inputs; OMemData <= MemRData if read, else 0.
//     - Same edge: -> IDLE.
//   - MemAck=0, counter<TIMEOUT-1: EXMEMWrite=0. Counter++.
//   - MemAck=0, counter=TIMEOUT-1: EXMEMWrite=1.
//     - Next edge: MemReq<=0, MemErr<=1, MEM/WB <= inputs with ORegWrite forced 0 and
//       OMemData 0.
//     - Same edge: -> IDLE.
// - Latency: non-memory = 1 cycle. Memory = 1 + (cycles until ack), min 2.
// - MemAck while MemReq=0 ignored. MemErr high exactly one cycle, else 0.
// - MemAddr/MemWData/MemWE never change while MemReq=1, even if inputs change.
// - Back-to-back accesses: after ack, IDLE sees the next instruction; new MemReq one cycle later.
//   MemReq is therefore low for >=1 cycle between requests.
// - Address/data are plain W-bit copies: no alignment checks, no arithmetic.
// TESTING
// 1. ALU op IRegWrite=1, IALUResult=16'h1234, IRd=3.
//    -> next edge ORegWrite=1, OALUResult=16'h1234, ORd=3; EXMEMWrite stays 1; MemReq stays 0.
// 2. Load IALUResult=16'h0040; MemAck pulses 2 cycles after MemReq rises, MemRData=16'hBEEF.
//    -> MemReq=1, MemWE=0, MemAddr=16'h0040; EXMEMWrite=0 for 3 cycles.
//    -> then OMemData=16'hBEEF, ORegWrite=1.
// 3. Store IALUResult=16'h0010, I3rdArg=16'hA5A5, ack on 1st WAIT cycle.
//    -> MemWE=1, MemWData=16'hA5A5; 2-cycle occupancy; OMemData=0.
// 4. Load with MemAck never asserted, TIMEOUT=15.
//    -> MemReq high 15 cycles; then MemErr one-cycle pulse, ORegWrite=0, EXMEMWrite=1.
// 5. Reset low mid-WAIT (MemReq=1).
//    -> MemReq, ORegWrite and MemErr go 0 without a clock edge; after release, state IDLE.
// 6. IMemRead=IMemWrite=1, then stray MemAck with MemReq=0.
//    -> write performed (MemWE=1); stray ack ignored, no state change.

Source files
------------

// File: rtl/mem_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_ctrl
// Description : MEM pipeline stage controller. Consumes the EX/MEM register,
//               runs the data-memory access over a req/ack handshake with a
//               timeout abort, stalls EX/MEM while the access is pending and
//               drives the MEM/WB fields.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage_ctrl #(
  parameter int W       = 16,
  parameter int TIMEOUT = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_reg_write,
  input  logic         i_mem_write,
  input  logic         i_mem_read,
  input  logic         i_reg_store,
  input  logic [W-1:0] i_pcp2,
  input  logic [W-1:0] i_alu_result,
  input  logic [W-1:0] i_3rd_arg,
  input  logic [W-1:0] i_rd,
  input  logic         i_mem_ack,
  input  logic [W-1:0] i_mem_rdata,
  output logic         o_mem_req,
  output logic         o_mem_we,
  output logic [W-1:0] o_mem_addr,
  output logic [W-1:0] o_mem_wdata,
  output logic         o_exmem_write,
  output logic         o_mem_err,
  output logic         o_reg_write,
  output logic         o_reg_store,
  output logic [W-1:0] o_pcp2,
  output logic [W-1:0] o_alu_result,
  output logic [W-1:0] o_mem_data,
  output logic [W-1:0] o_rd
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  // Last counter value before the request is abandoned.
  localparam logic [7:0] c_last = 8'(TIMEOUT - 1);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_cnt;
  logic       w_access;
  logic       w_timeout;
  logic       w_exmem_write;

  assign w_access      = i_mem_read | i_mem_write;
  assign w_timeout     = (r_cnt == c_last);
  assign o_exmem_write = w_exmem_write;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and EX/MEM write enable; the stage stalls only while an access
  // is being launched or is still waiting without ack or timeout.
  always_comb begin
    w_state_nxt   = r_state;
    w_exmem_write = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (w_access) begin
          w_exmem_write = 1'b0;
          w_state_nxt   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (i_mem_ack || w_timeout) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_exmem_write = 1'b0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Memory request, timeout counter and MEM/WB field registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt        <= 8'd0;
      o_mem_req    <= 1'b0;
      o_mem_we     <= 1'b0;
      o_mem_addr   <= '0;
      o_mem_wdata  <= '0;
      o_mem_err    <= 1'b0;
      o_reg_write  <= 1'b0;
      o_reg_store  <= 1'b0;
      o_pcp2       <= '0;
      o_alu_result <= '0;
      o_mem_data   <= '0;
      o_rd         <= '0;
    end else begin
      o_mem_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_access) begin
            // Launch: capture the request fields, which then stay frozen
            // while the request is up, and send a bubble down to MEM/WB.
            o_mem_req   <= 1'b1;
            o_mem_we    <= i_mem_write;
            o_mem_addr  <= i_alu_result;
            o_mem_wdata <= i_3rd_arg;
            o_reg_write <= 1'b0;
            o_reg_store <= 1'b0;
            r_cnt       <= 8'd0;
          end else begin
            o_reg_write  <= i_reg_write;
            o_reg_store  <= i_reg_store;
            o_pcp2       <= i_pcp2;
            o_alu_result <= i_alu_result;
            o_rd         <= i_rd;
            o_mem_data   <= '0;
          end
        end
        S_WAIT: begin
          if (i_mem_ack) begin
            o_mem_req    <= 1'b0;
            o_reg_write  <= i_reg_write;
            o_reg_store  <= i_reg_store;
            o_pcp2       <= i_pcp2;
            o_alu_result <= i_alu_result;
            o_rd         <= i_rd;
            o_mem_data   <= o_mem_we ? '0 : i_mem_rdata;
          end else if (w_timeout) begin
            // Abort: retire the instruction without a register writeback.
            o_mem_req    <= 1'b0;
            o_mem_err    <= 1'b1;
            o_reg_write  <= 1'b0;
            o_reg_store  <= i_reg_store;
            o_pcp2       <= i_pcp2;
            o_alu_result <= i_alu_result;
            o_rd         <= i_rd;
            o_mem_data   <= '0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: begin
          o_mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_stage_ctrl
// Description : Self-checking bench for mem_stage_ctrl. Expected MEM/WB
//               results are queued when an instruction is presented and
//               compared when the stage retires it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_reg_write, i_mem_write, i_mem_read, i_reg_store;
  logic [15:0] i_pcp2, i_alu_result, i_3rd_arg, i_rd;
  logic        i_mem_ack;
  logic [15:0] i_mem_rdata;
  logic        o_mem_req, o_mem_we, o_exmem_write, o_mem_err;
  logic        o_reg_write, o_reg_store;
  logic [15:0] o_mem_addr, o_mem_wdata, o_pcp2, o_alu_result, o_mem_data, o_rd;

  int n_total = 0;
  int n_pass  = 0;

  typedef struct packed {
    logic        rw;
    logic        rs;
    logic [15:0] pc;
    logic [15:0] alu;
    logic [15:0] md;
    logic [15:0] rd;
    logic        err;
  } exp_t;

  exp_t sb_q[$];

  mem_stage_ctrl #(.W(16), .TIMEOUT(15)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_reg_write  (i_reg_write),
    .i_mem_write  (i_mem_write),
    .i_mem_read   (i_mem_read),
    .i_reg_store  (i_reg_store),
    .i_pcp2       (i_pcp2),
    .i_alu_result (i_alu_result),
    .i_3rd_arg    (i_3rd_arg),
    .i_rd         (i_rd),
    .i_mem_ack    (i_mem_ack),
    .i_mem_rdata  (i_mem_rdata),
    .o_mem_req    (o_mem_req),
    .o_mem_we     (o_mem_we),
    .o_mem_addr   (o_mem_addr),
    .o_mem_wdata  (o_mem_wdata),
    .o_exmem_write(o_exmem_write),
    .o_mem_err    (o_mem_err),
    .o_reg_write  (o_reg_write),
    .o_reg_store  (o_reg_store),
    .o_pcp2       (o_pcp2),
    .o_alu_result (o_alu_result),
    .o_mem_data   (o_mem_data),
    .o_rd         (o_rd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Present one instruction from EX/MEM and hold it until the stage accepts
  // it. ack_k >= 0: ack on WAIT cycle ack_k; -1: stray ack in the IDLE cycle;
  // -2: never ack.
  task automatic run_instr(input logic rw, input logic mw, input logic mr, input logic rs,
                           input logic [15:0] pc, input logic [15:0] alu,
                           input logic [15:0] d3, input logic [15:0] rd,
                           input int ack_k, input logic [15:0] rdata,
                           input int exp_stall);
    exp_t e;
    logic acc;
    logic done;
    int   stall;
    int   reqc;
    int   exp_req;
    acc          = mr | mw;
    i_reg_write  = rw;
    i_mem_write  = mw;
    i_mem_read   = mr;
    i_reg_store  = rs;
    i_pcp2       = pc;
    i_alu_result = alu;
    i_3rd_arg    = d3;
    i_rd         = rd;
    e.err = acc && (ack_k == -2);
    e.rw  = rw && !e.err;
    e.rs  = rs;
    e.pc  = pc;
    e.alu = alu;
    e.rd  = rd;
    e.md  = (acc && !mw && ack_k >= 0) ? rdata : 16'h0000;
    sb_q.push_back(e);
    exp_req = !acc ? 0 : (ack_k == -2 ? 15 : ack_k + 1);
    done  = 1'b0;
    stall = 0;
    reqc  = 0;
    for (int n = 0; n < 40 && !done; n++) begin
      i_mem_ack   = (ack_k != -2) && (n == ack_k + 1);
      i_mem_rdata = i_mem_ack ? rdata : 16'hDEAD;
      #1;
      if (n >= 1) begin
        if (o_mem_req) reqc++;
        chk("req_we", o_mem_we, mw);
        chk("req_addr", o_mem_addr, alu);
        if (mw) chk("req_wdata", o_mem_wdata, d3);
      end
      if (o_exmem_write) done = 1'b1;
      else stall++;
      @(posedge clk);
      @(negedge clk);
    end
    i_mem_ack = 1'b0;
    if (!done) begin
      n_total++;
      $error("FAIL retire_budget observed=no_retire expected=retire");
    end
    chk("stall_cycles", stall, exp_stall);
    chk("req_cycles", reqc, exp_req);
    e = sb_q.pop_front();
    chk("mem_req_after", o_mem_req, 1'b0);
    chk("mem_err", o_mem_err, e.err);
    chk("reg_write", o_reg_write, e.rw);
    chk("reg_store", o_reg_store, e.rs);
    chk("pcp2", o_pcp2, e.pc);
    chk("alu_result", o_alu_result, e.alu);
    chk("mem_data", o_mem_data, e.md);
    chk("rd", o_rd, e.rd);
  endtask

  initial begin
    rst_n = 1'b0;
    {i_reg_write, i_mem_write, i_mem_read, i_reg_store} = 4'b0;
    i_pcp2 = '0; i_alu_result = '0; i_3rd_arg = '0; i_rd = '0;
    i_mem_ack = 1'b0; i_mem_rdata = '0;
    @(negedge clk);
    @(negedge clk);
    // Reset state
    chk("rst_mem_req", o_mem_req, 1'b0);
    chk("rst_mem_err", o_mem_err, 1'b0);
    chk("rst_reg_write", o_reg_write, 1'b0);
    chk("rst_alu_result", o_alu_result, 16'h0);
    chk("rst_exmem_write", o_exmem_write, 1'b1);
    rst_n = 1'b1;

    // 1. ALU op passes through in one cycle
    run_instr(1'b1, 1'b0, 1'b0, 1'b0, 16'h0102, 16'h1234, 16'h0000, 16'h0003, -2, 16'h0, 0);
    // 2. Load acked on the third WAIT cycle
    run_instr(1'b1, 1'b0, 1'b1, 1'b1, 16'h0104, 16'h0040, 16'h0000, 16'h0005, 2, 16'hBEEF, 3);
    // 3. Store acked on the first WAIT cycle
    run_instr(1'b0, 1'b1, 1'b0, 1'b0, 16'h0106, 16'h0010, 16'hA5A5, 16'h0000, 0, 16'h7777, 1);
    // Back-to-back load right after the store
    run_instr(1'b1, 1'b0, 1'b1, 1'b0, 16'h0108, 16'hFFFE, 16'h0000, 16'h0007, 1, 16'h1357, 2);
    // 4. Load never acked: timeout abort
    run_instr(1'b1, 1'b0, 1'b1, 1'b0, 16'h010A, 16'h0020, 16'h0000, 16'h0002, -2, 16'h0, 15);
    i_mem_read = 1'b0;
    @(negedge clk);
    chk("err_one_cycle", o_mem_err, 1'b0);

    // 5. Asynchronous reset in the middle of WAIT
    i_reg_write = 1'b1; i_mem_read = 1'b1; i_alu_result = 16'h0077;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_req", o_mem_req, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_req", o_mem_req, 1'b0);
    chk("async_rst_reg_write", o_reg_write, 1'b0);
    chk("async_rst_err", o_mem_err, 1'b0);
    chk("async_rst_addr", o_mem_addr, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    i_mem_read = 1'b0;
    #1;
    chk("post_rst_idle", o_exmem_write, 1'b1);
    run_instr(1'b1, 1'b0, 1'b0, 1'b1, 16'h0200, 16'h4321, 16'h0000, 16'h0001, -2, 16'h0, 0);

    // 6. Read and write both set: the write wins
    run_instr(1'b1, 1'b1, 1'b1, 1'b0, 16'h0202, 16'h0030, 16'h5A5A, 16'h0004, 1, 16'h1111, 2);
    // Stray ack while no request is up
    run_instr(1'b1, 1'b0, 1'b0, 1'b0, 16'h0204, 16'h0055, 16'h0000, 16'h0006, -1, 16'hFFFF, 0);
    chk("stray_no_err", o_mem_err, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
